// File: rtl/io_cond_pkg.sv
// rtl/io_cond_pkg.sv - shared constants and helpers for the input conditioning bank
package io_cond_pkg;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MIN_DEBOUNCE    = 1;

  // Counter must hold 0..cycles, so width is clog2(cycles+1), never below one bit
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - single-bit resettable synchronizer flop chain
module sync_chain #(
  parameter int   STAGES    = 3,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage;

  // Shift the raw input through the chain; stage[0] sees only d
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= {STAGES{RESET_BIT}};
    end else begin
      stage <= {stage[STAGES-2:0], d};
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/sync_debounce_bank.sv
// rtl/sync_debounce_bank.sv - multi-channel synchronizer, debounce filter and edge pulses
module sync_debounce_bank
  import io_cond_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               STAGES          = 3,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_edge
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (WIDTH < 1) begin : g_bad_width
    $error("sync_debounce_bank: WIDTH must be at least 1");
  end
  if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("sync_debounce_bank: STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < MIN_DEBOUNCE) begin : g_bad_debounce
    $error("sync_debounce_bank: DEBOUNCE_CYCLES must be at least 1");
  end

  // One bit per channel: the synchronized value has persisted long enough to be accepted
  logic [WIDTH-1:0] update;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [CW-1:0] cnt;

    sync_chain #(
      .STAGES    (STAGES),
      .RESET_BIT (RESET_VAL[i])
    ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (async_in[i]),
      .q   (sync_out[i])
    );

    assign update[i] = (sync_out[i] != level[i]) && (cnt == CNT_LAST);

    // Count consecutive mismatch cycles; any agreement or an accepted change restarts it
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if ((sync_out[i] == level[i]) || update[i]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Accepted changes move level and raise the matching pulse in the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      level    <= RESET_VAL;
      rise     <= '0;
      fall     <= '0;
      any_edge <= 1'b0;
    end else begin
      level    <= (level & ~update) | (sync_out & update);
      rise     <= update & sync_out;
      fall     <= update & ~sync_out;
      any_edge <= |update;
    end
  end

endmodule

// File: tb/tb_sync_debounce_bank.sv
// tb/tb_sync_debounce_bank.sv - randomized and directed bench for sync_debounce_bank
module tb_sync_debounce_bank;

  localparam int W = 4;
  localparam int S = 3;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] sync_out, level, rise, fall;
  logic         any_edge;
  logic [W-1:0] a_hi = 4'hF;
  logic [W-1:0] sync_hi, level_hi, rise_hi, fall_hi;
  logic         any_hi;

  int checks = 0;
  int errors = 0;

  sync_debounce_bank #(
    .WIDTH(W), .STAGES(S), .DEBOUNCE_CYCLES(D), .RESET_VAL(4'b0000)
  ) dut (
    .clk(clk), .rst(rst), .async_in(a_in), .sync_out(sync_out),
    .level(level), .rise(rise), .fall(fall), .any_edge(any_edge)
  );

  sync_debounce_bank #(
    .WIDTH(W), .STAGES(S), .DEBOUNCE_CYCLES(D), .RESET_VAL(4'b1111)
  ) dut_hi (
    .clk(clk), .rst(rst), .async_in(a_hi), .sync_out(sync_hi),
    .level(level_hi), .rise(rise_hi), .fall(fall_hi), .any_edge(any_hi)
  );

  always #5 clk = ~clk;

  // Reference model: sync_out is the input delayed S clocks; level flips when the
  // last D sampled sync values all disagree with it.
  logic [W-1:0] m_pipe [S];
  logic [W-1:0] m_level, m_rise, m_fall;
  logic         m_any;
  bit           hist [W][$];

  always @(posedge clk) begin
    logic [W-1:0] s, upd;
    bit all_diff;
    if (rst) begin
      for (int k = 0; k < S; k++) m_pipe[k] = '0;
      m_level = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
      for (int c = 0; c < W; c++) hist[c].delete();
    end else begin
      s = m_pipe[S-1];
      upd = '0;
      for (int c = 0; c < W; c++) begin
        hist[c].push_back(s[c]);
        if (hist[c].size() > D) void'(hist[c].pop_front());
        if (hist[c].size() == D) begin
          all_diff = 1'b1;
          for (int q = 0; q < D; q++) if (hist[c][q] == m_level[c]) all_diff = 1'b0;
          upd[c] = all_diff;
        end
      end
      m_rise  = upd & s;
      m_fall  = upd & ~s;
      m_any   = |upd;
      m_level = (m_level & ~upd) | (s & upd);
      for (int k = S-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = a_in;
    end
  end

  task automatic test_reset();
    rst = 1'b1; a_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      checks++;
      if (level !== 4'b0 || sync_out !== 4'b0 || rise !== 4'b0 || fall !== 4'b0 || any_edge !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: level=%b sync=%b rise=%b fall=%b any=%b, required all 0",
                 j, level, sync_out, rise, fall, any_edge);
      end
    end
  endtask

  task automatic test_single_rise();
    int pulses = 0;
    a_in[0] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checks++;
      if (sync_out[0] !== (j >= 2) || level[0] !== (j >= 6) || rise[0] !== (j == 6) ||
          any_edge !== (j == 6) || fall !== 4'b0) begin
        errors++;
        $display("FAIL single_rise E+%0d: sync0=%b level0=%b rise0=%b any=%b fall=%b, required %b %b %b %b 0000",
                 j, sync_out[0], level[0], rise[0], any_edge, fall, j >= 2, j >= 6, j == 6, j == 6);
      end
      if (rise[0]) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL single_rise_count: pulses=%0d, required 1", pulses);
    end
  endtask

  task automatic test_glitch();
    int highs = 0;
    int bad = 0;
    a_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    a_in[1] = 1'b0;
    for (int j = 0; j < 9; j++) begin
      if (sync_out[1]) highs++;
      if (level[1] || rise !== 4'b0 || fall !== 4'b0 || any_edge) bad++;
      @(negedge clk);
    end
    checks++;
    if (highs != 3) begin
      errors++;
      $display("FAIL glitch_sync_width: sync_out[1] high %0d cycles, required 3", highs);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL glitch_rejected: %0d cycles with level/pulse activity, required 0", bad);
    end
  endtask

  task automatic test_simultaneous();
    int any_cnt = 0;
    a_in[3] = 1'b1;
    repeat (12) @(negedge clk);
    a_in[2] = 1'b1; a_in[3] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checks++;
      if (rise !== ((j == 6) ? 4'b0100 : 4'b0000) || fall !== ((j == 6) ? 4'b1000 : 4'b0000)) begin
        errors++;
        $display("FAIL simultaneous E+%0d: rise=%b fall=%b, required %b %b", j, rise, fall,
                 (j == 6) ? 4'b0100 : 4'b0000, (j == 6) ? 4'b1000 : 4'b0000);
      end
      if (any_edge) any_cnt++;
    end
    checks++;
    if (any_cnt != 1) begin
      errors++;
      $display("FAIL simultaneous_any: any_edge high %0d cycles, required 1", any_cnt);
    end
  endtask

  task automatic test_reset_mid_debounce();
    rst = 1'b1; a_in = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    a_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (level !== 4'b0 || sync_out !== 4'b0 || rise !== 4'b0 || fall !== 4'b0 || any_edge !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: level=%b sync=%b rise=%b fall=%b any=%b, required all 0",
               level, sync_out, rise, fall, any_edge);
    end
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checks++;
      if (level[0] !== (j >= 6) || rise[0] !== (j == 6)) begin
        errors++;
        $display("FAIL mid_reset_relatch R+%0d: level0=%b rise0=%b, required %b %b",
                 j, level[0], rise[0], j >= 6, j == 6);
      end
    end
  endtask

  task automatic test_reset_val_high();
    int bad = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (level_hi !== 4'hF || sync_hi !== 4'hF || rise_hi !== 4'b0 || fall_hi !== 4'b0 || any_hi !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_val_high: %0d bad cycles (last level=%b rise=%b), required 0 with level 1111",
               bad, level_hi, rise_hi);
    end
  endtask

  task automatic test_random();
    int printed = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 2000; j++) begin
      @(negedge clk);
      checks++;
      if (sync_out !== m_pipe[S-1] || level !== m_level || rise !== m_rise ||
          fall !== m_fall || any_edge !== m_any || (rise & fall) !== 4'b0) begin
        errors++;
        if (printed < 20) begin
          printed++;
          $display("FAIL random cyc%0d: sync=%b level=%b rise=%b fall=%b any=%b, required %b %b %b %b %b",
                   j, sync_out, level, rise, fall, any_edge, m_pipe[S-1], m_level, m_rise, m_fall, m_any);
        end
      end
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) a_in[$urandom_range(0, W-1)] ^= 1'b1;
      if ($urandom_range(0, 39) == 0) a_in = W'($urandom);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_simultaneous();
    test_reset_mid_debounce();
    test_reset_val_high();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
